// File: rtl/exp_bus_pkg.sv
// Shared register map and master FSM state type for the exponent accelerator bus.
// Imported by both the bus master and any slave model so the map has one source.
package exp_bus_pkg;

   localparam logic [3:0]  EXP_X_OFS         = 4'h0;
   localparam logic [3:0]  EXP_A_OFS         = 4'h4;
   localparam logic [3:0]  EXP_CTRL_OFS      = 4'h8;
   localparam logic [3:0]  EXP_RES_OFS       = 4'hC;

   localparam logic [31:0] EXP_CTRL_START    = 32'h1;
   localparam int unsigned EXP_STAT_DONE_BIT = 0;

   typedef enum logic [2:0] {
      StIdle,
      StWrX,
      StWrA,
      StWrGo,
      StPoll,
      StRdRes,
      StResp
   } master_state_e;

endpackage

// File: rtl/exponent_bus_cycle.sv
// Single bus access engine: one strobe cycle followed by ReadLat idle cycles.
// Owns the bus pins; read data is presented with done_o on the last idle cycle.
module exponent_bus_cycle #(
   parameter int unsigned ReadLat = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        exp_select_o,
   output logic        as_l_o,
   output logic        we_l_o,
   output logic [3:0]  addr_o,
   output logic [31:0] writedata_o,
   input  logic [31:0] readdata_i
);

   localparam int unsigned CntW = $clog2(ReadLat + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(ReadLat);

   logic            busy_q;
   logic [CntW-1:0] cnt_q;
   logic            sel_q;
   logic            as_l_q;
   logic            we_l_q;
   logic [3:0]      addr_q;
   logic [31:0]     wdata_q;
   logic            last;

   // Last post-strobe cycle: readdata is sampled and a new start may be taken.
   assign last   = busy_q && as_l_q && (cnt_q == CntLast);
   assign busy_o = busy_q && !last;
   assign done_o = last;
   assign rdata_o = last ? readdata_i : 32'h0;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         as_l_q  <= 1'b1;
         we_l_q  <= 1'b1;
         addr_q  <= 4'h0;
         wdata_q <= 32'h0;
      end else if (start_i && !busy_o) begin
         busy_q  <= 1'b1;
         cnt_q   <= '0;
         sel_q   <= 1'b1;
         as_l_q  <= 1'b0;
         we_l_q  <= !we_i;
         addr_q  <= addr_i;
         wdata_q <= we_i ? wdata_i : 32'h0;
      end else if (busy_q) begin
         if (!as_l_q) begin
            sel_q   <= 1'b0;
            as_l_q  <= 1'b1;
            we_l_q  <= 1'b1;
            addr_q  <= 4'h0;
            wdata_q <= 32'h0;
            cnt_q   <= CntW'(1);
         end else if (last) begin
            busy_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

   assign exp_select_o = sel_q;
   assign as_l_o       = as_l_q;
   assign we_l_o       = we_l_q;
   assign addr_o       = addr_q;
   assign writedata_o  = wdata_q;

endmodule

// File: rtl/exponent_bus_master.sv
// Bus master that programs the exponent accelerator (X, A, START), polls STATUS,
// reads RESULT and returns it on a valid/ready response port.
module exponent_bus_master
   import exp_bus_pkg::*;
#(
   parameter int unsigned READ_LAT = 2,
   parameter int unsigned POLL_MAX = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_x,
   input  logic [31:0] req_a,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_p,
   output logic        rsp_timeout,
   output logic        exp_select,
   output logic        AS_L,
   output logic        WE_L,
   output logic [3:0]  addr,
   output logic [31:0] writedata,
   input  logic [31:0] readdata
);

   localparam int unsigned PollW = $clog2(POLL_MAX + 1);
   localparam logic [PollW-1:0] PollMax = PollW'(POLL_MAX);

   master_state_e    state_q, state_d;
   logic [31:0]      a_q, a_d;
   logic [PollW-1:0] poll_q, poll_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_p_q, rsp_p_d;
   logic             rsp_to_q, rsp_to_d;

   logic             launch;
   logic             bus_start;
   logic             bus_we;
   logic [3:0]       bus_addr;
   logic [31:0]      bus_wdata;
   logic             bus_busy;
   logic             bus_done;
   logic [31:0]      bus_rdata;
   logic [PollW-1:0] poll_inc;

   assign poll_inc  = (poll_q == PollMax) ? poll_q : poll_q + PollW'(1);
   assign bus_start = launch && !bus_busy;

   // Each access is launched on the transition into the state that waits for it,
   // so the next strobe follows the previous access's last cycle directly.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      poll_d      = poll_q;
      rsp_valid_d = rsp_valid_q;
      rsp_p_d     = rsp_p_q;
      rsp_to_d    = rsp_to_q;
      launch      = 1'b0;
      bus_we      = 1'b0;
      bus_addr    = EXP_X_OFS;
      bus_wdata   = 32'h0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               // X is held by the bus engine's writedata register during its strobe.
               a_d       = req_a;
               launch    = 1'b1;
               bus_we    = 1'b1;
               bus_addr  = EXP_X_OFS;
               bus_wdata = req_x;
               state_d   = StWrX;
            end
         end
         StWrX: begin
            if (bus_done) begin
               launch    = 1'b1;
               bus_we    = 1'b1;
               bus_addr  = EXP_A_OFS;
               bus_wdata = a_q;
               state_d   = StWrA;
            end
         end
         StWrA: begin
            if (bus_done) begin
               launch    = 1'b1;
               bus_we    = 1'b1;
               bus_addr  = EXP_CTRL_OFS;
               bus_wdata = EXP_CTRL_START;
               state_d   = StWrGo;
            end
         end
         StWrGo: begin
            if (bus_done) begin
               launch   = 1'b1;
               bus_addr = EXP_CTRL_OFS;
               poll_d   = poll_inc;
               state_d  = StPoll;
            end
         end
         StPoll: begin
            if (bus_done) begin
               if (bus_rdata[EXP_STAT_DONE_BIT]) begin
                  launch   = 1'b1;
                  bus_addr = EXP_RES_OFS;
                  state_d  = StRdRes;
               end else if (poll_q == PollMax) begin
                  rsp_p_d     = 32'h0;
                  rsp_to_d    = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = StResp;
               end else begin
                  launch   = 1'b1;
                  bus_addr = EXP_CTRL_OFS;
                  poll_d   = poll_inc;
               end
            end
         end
         StRdRes: begin
            if (bus_done) begin
               rsp_p_d     = bus_rdata;
               rsp_to_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               poll_d      = '0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         a_q         <= 32'h0;
         poll_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_p_q     <= 32'h0;
         rsp_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         poll_q      <= poll_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_p_q     <= rsp_p_d;
         rsp_to_q    <= rsp_to_d;
      end
   end

   exponent_bus_cycle #(
      .ReadLat (READ_LAT)
   ) u_bus_cycle (
      .clk_i        (clk),
      .rst_ni       (reset_n),
      .start_i      (bus_start),
      .we_i         (bus_we),
      .addr_i       (bus_addr),
      .wdata_i      (bus_wdata),
      .busy_o       (bus_busy),
      .done_o       (bus_done),
      .rdata_o      (bus_rdata),
      .exp_select_o (exp_select),
      .as_l_o       (AS_L),
      .we_l_o       (WE_L),
      .addr_o       (addr),
      .writedata_o  (writedata),
      .readdata_i   (readdata)
   );

   assign req_ready   = (state_q == StIdle);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_p       = rsp_p_q;
   assign rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_exponent_bus_master.sv
// Bench for exponent_bus_master with a behavioural accelerator slave, a bus
// protocol monitor and directed plus randomized requests.
module tb_exponent_bus_master;
   import exp_bus_pkg::*;

   localparam int unsigned READ_LAT = 2;
   localparam int unsigned POLL_MAX = 8;
   localparam int          MIN_LAT  = 5 * (1 + READ_LAT) + 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_x = 32'h0;
   logic [31:0] req_a = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_p;
   logic        rsp_timeout;
   logic        exp_select;
   logic        AS_L;
   logic        WE_L;
   logic [3:0]  addr;
   logic [31:0] writedata;
   logic [31:0] readdata;

   int checks = 0;
   int errors = 0;

   exponent_bus_master #(
      .READ_LAT (READ_LAT),
      .POLL_MAX (POLL_MAX)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x       (req_x),
      .req_a       (req_a),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_p       (rsp_p),
      .rsp_timeout (rsp_timeout),
      .exp_select  (exp_select),
      .AS_L        (AS_L),
      .WE_L        (WE_L),
      .addr        (addr),
      .writedata   (writedata),
      .readdata    (readdata)
   );

   always #5 clk = ~clk;

   // x**a modulo 2**32 by repeated multiplication.
   function automatic logic [31:0] pow32(input logic [31:0] x, input logic [31:0] a);
      logic [31:0] r = 32'h1;
      for (int unsigned i = 0; i < a; i++) r = r * x;
      return r;
   endfunction

   // Behavioural slave: registers X/A, runs for slave_lat cycles after START.
   int          slave_lat = 0;
   bit          slave_never = 1'b0;
   logic [31:0] s_x, s_a;
   logic        s_done, s_run;
   int          s_cnt;

   always @(posedge clk) begin
      if (!reset_n) begin
         s_x <= 32'h0; s_a <= 32'h0; s_done <= 1'b0; s_run <= 1'b0; s_cnt <= 0;
         readdata <= 32'h0;
      end else begin
         if (s_run) begin
            if (s_cnt == 0) begin s_done <= 1'b1; s_run <= 1'b0; end
            else s_cnt <= s_cnt - 1;
         end
         if (exp_select && !AS_L) begin
            if (!WE_L) begin
               if (addr == EXP_X_OFS) s_x <= writedata;
               if (addr == EXP_A_OFS) s_a <= writedata;
               if (addr == EXP_CTRL_OFS && writedata[0]) begin
                  s_done <= 1'b0; s_run <= !slave_never; s_cnt <= slave_lat;
               end
            end else begin
               if (addr == EXP_CTRL_OFS) readdata <= {31'h0, s_done};
               else if (addr == EXP_RES_OFS) readdata <= pow32(s_x, s_a);
               else readdata <= 32'hDEAD_BEEF;
            end
         end
      end
   end

   // Bus monitor: strobe trace plus protocol rule violations.
   logic [36:0] trace[$];
   int          bus_err = 0;
   int          gap = 100;

   always @(negedge clk) begin
      if (!reset_n) begin
         gap = 100;
      end else begin
         if (exp_select !== ~AS_L) bus_err++;
         if (AS_L && !WE_L) bus_err++;
         if (!AS_L) begin
            if (gap < int'(READ_LAT)) bus_err++;
            gap = 0;
            trace.push_back({~WE_L, addr, WE_L ? 32'h0 : writedata});
         end else begin
            gap++;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // One request; holds rsp_ready low for `hold` cycles while poking req_valid.
   task automatic run_req(input string tag, input logic [31:0] x, input logic [31:0] a,
                          input int lat, input bit never, input int hold,
                          output logic [31:0] got_p, output logic got_to, output int cyc);
      int n = 0;
      slave_lat = lat;
      slave_never = never;
      while (!req_ready && n < 50) begin step(); n++; end
      req_x = x; req_a = a; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      cyc = 1;
      while (!rsp_valid && cyc < 300) begin step(); cyc++; end
      chk({tag, "_rsp_seen"}, 64'(rsp_valid), 64'h1);
      got_p = rsp_p;
      got_to = rsp_timeout;
      for (int i = 0; i < hold; i++) begin
         req_valid = i[0];
         req_x = $urandom; req_a = $urandom;
         step();
         chk({tag, "_hold_stable"}, {31'h0, rsp_valid, rsp_timeout, rsp_p},
             {31'h0, 1'b1, got_to, got_p});
         chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'h0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, "_idle_after"}, {62'h0, req_ready, rsp_valid}, 64'h2);
   endtask

   logic [31:0] p;
   logic        to;
   int          cyc, t0, polls, n;
   logic [31:0] rx, ra;

   initial begin
      repeat (3) step();
      chk("reset_outputs", {req_ready, rsp_valid, rsp_timeout, exp_select, AS_L, WE_L, addr},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0});
      chk("reset_data", {rsp_p, writedata}, 64'h0);
      reset_n = 1'b1;
      step();

      // Test 1: 3**4 with slave latency 6, check full bus trace.
      t0 = trace.size();
      run_req("t1", 32'd3, 32'd4, 6, 1'b0, 0, p, to, cyc);
      chk("t1_p", 64'(p), 64'd81);
      chk("t1_to", 64'(to), 64'h0);
      chk("t1_wx", 64'(trace[t0]), {27'h0, 1'b1, EXP_X_OFS, 32'd3});
      chk("t1_wa", 64'(trace[t0+1]), {27'h0, 1'b1, EXP_A_OFS, 32'd4});
      chk("t1_wgo", 64'(trace[t0+2]), {27'h0, 1'b1, EXP_CTRL_OFS, 32'h1});
      chk("t1_rres", 64'(trace[trace.size()-1]), {27'h0, 1'b0, EXP_RES_OFS, 32'h0});
      polls = 0;
      for (int i = t0 + 3; i < trace.size() - 1; i++)
         if (trace[i] == {1'b0, EXP_CTRL_OFS, 32'h0}) polls++;
      chk("t1_polls_only", 64'(polls), 64'(trace.size() - 1 - (t0 + 3)));
      chk("t1_polls_some", 64'(polls >= 2), 64'h1);

      // Test 2: edge exponents; the first also measures minimum latency.
      run_req("t2a", 32'd7, 32'd0, 0, 1'b0, 0, p, to, cyc);
      chk("t2a_p", 64'(p), 64'd1);
      chk("t2a_latency", 64'(cyc), 64'(MIN_LAT));
      run_req("t2b", 32'd2, 32'd31, 3, 1'b0, 0, p, to, cyc);
      chk("t2b_p", 64'(p), 64'h8000_0000);
      run_req("t2c", 32'd2, 32'd33, 1, 1'b0, 0, p, to, cyc);
      chk("t2c_p", {p, 31'h0, to}, 64'h0);

      // Test 3: consumer stalls 5 cycles.
      run_req("t3", 32'd5, 32'd3, 2, 1'b0, 5, p, to, cyc);
      chk("t3_p", 64'(p), 64'd125);

      // Test 4: slave never finishes -> timeout after exactly POLL_MAX reads.
      t0 = trace.size();
      run_req("t4", 32'd9, 32'd9, 0, 1'b1, 0, p, to, cyc);
      chk("t4_resp", {p, 31'h0, to}, 64'h1);
      polls = 0;
      for (int i = t0; i < trace.size(); i++)
         if (trace[i] == {1'b0, EXP_CTRL_OFS, 32'h0}) polls++;
      chk("t4_status_reads", 64'(polls), 64'(POLL_MAX));

      // Test 5: reset asserted during a STATUS strobe.
      slave_never = 1'b1;
      req_x = 32'd4; req_a = 32'd4; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      n = 0;
      while (!(!AS_L && WE_L && addr == EXP_CTRL_OFS) && n < 100) begin step(); n++; end
      chk("t5_poll_strobe_seen", 64'(!AS_L), 64'h1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("t5_after_reset", {60'h0, AS_L, exp_select, req_ready, rsp_valid}, 64'b1010);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (rsp_valid) n++;
      end
      chk("t5_no_rsp", 64'(n), 64'h0);
      run_req("t5b", 32'd10, 32'd2, 2, 1'b0, 0, p, to, cyc);
      chk("t5b_p", {p, 31'h0, to}, {32'd100, 32'h0});

      // Randomized requests against the arithmetic reference.
      for (int k = 0; k < 8; k++) begin
         rx = $urandom;
         if (k < 3) rx = 32'($urandom_range(0, 5));
         ra = 32'($urandom_range(0, 40));
         run_req("rnd", rx, ra, int'($urandom_range(0, 12)), 1'b0, int'($urandom_range(0, 3)),
                 p, to, cyc);
         chk($sformatf("rnd%0d_p", k), {p, 31'h0, to}, {pow32(rx, ra), 32'h0});
      end

      chk("bus_protocol", 64'(bus_err), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
